// File: rtl/cpu_pkg.sv
// Shared control-bundle layout and ALUOp encodings for the 5-stage core.
// Used by decode, the ID/EX and EX/MEM registers and the hazard unit.
package cpu_pkg;

  localparam int unsigned CTRL_W        = 7;
  localparam int unsigned CTRL_ALUSRC   = 6;
  localparam int unsigned CTRL_ALUOP_HI = 5;
  localparam int unsigned CTRL_ALUOP_LO = 4;
  localparam int unsigned CTRL_MEMWRITE = 3;
  localparam int unsigned CTRL_MEMREAD  = 2;
  localparam int unsigned CTRL_MEMTOREG = 1;
  localparam int unsigned CTRL_REGWRITE = 0;

  // All-zero bundle: no register write, no memory access.
  localparam logic [CTRL_W-1:0] CTRL_NOP = '0;

  typedef enum logic [1:0] {
    ALUOP_LDST   = 2'b00,
    ALUOP_BRANCH = 2'b01,
    ALUOP_RTYPE  = 2'b10,
    ALUOP_ITYPE  = 2'b11
  } aluop_e;

  function automatic logic ctrl_has_side_effect(input logic [CTRL_W-1:0] c);
    return c[CTRL_REGWRITE] | c[CTRL_MEMWRITE] | c[CTRL_MEMREAD];
  endfunction

endpackage

// File: rtl/id_ex_pipe_reg_sat_counter.sv
// Width-parameterised saturating incrementer with async active-low clear.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_cnt <= '0;
    end else if (inc_i && (r_cnt != '1)) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign cnt_o = r_cnt;

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register: flush > stall > load, per-entry valid bit,
// and a saturating count of bubbles loaded into the stage.
module id_ex_pipe_reg
  import cpu_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              noop_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [XLEN-1:0]   rs1_data_i,
  input  logic [XLEN-1:0]   rs2_data_i,
  input  logic [XLEN-1:0]   imm_i,
  input  logic [9:0]        funct_i,
  input  logic [4:0]        rs1_addr_i,
  input  logic [4:0]        rs2_addr_i,
  input  logic [4:0]        rd_addr_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [XLEN-1:0]   rs1_data_o,
  output logic [XLEN-1:0]   rs2_data_o,
  output logic [XLEN-1:0]   imm_o,
  output logic [9:0]        funct_o,
  output logic [4:0]        rs1_addr_o,
  output logic [4:0]        rs2_addr_o,
  output logic [4:0]        rd_addr_o,
  output logic              valid_o,
  output logic [CNT_W-1:0]  bubble_cnt_o
);

  logic [CTRL_W-1:0] r_ctrl;
  logic [XLEN-1:0]   r_rs1_data;
  logic [XLEN-1:0]   r_rs2_data;
  logic [XLEN-1:0]   r_imm;
  logic [9:0]        r_funct;
  logic [4:0]        r_rs1_addr;
  logic [4:0]        r_rs2_addr;
  logic [4:0]        r_rd_addr;
  logic              r_valid;

  logic w_load;
  logic w_bubble;

  assign w_load   = !flush_i && !stall_i;
  assign w_bubble = flush_i || (w_load && noop_i);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_ctrl     <= CTRL_NOP;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
      r_funct    <= '0;
      r_rs1_addr <= '0;
      r_rs2_addr <= '0;
      r_rd_addr  <= '0;
      r_valid    <= 1'b0;
    end else if (flush_i) begin
      r_ctrl     <= CTRL_NOP;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
      r_funct    <= '0;
      r_rs1_addr <= '0;
      r_rs2_addr <= '0;
      r_rd_addr  <= '0;
      r_valid    <= 1'b0;
    end else if (!stall_i) begin
      // Operand fields still load on a no-op; only the control bundle is squashed.
      r_ctrl     <= noop_i ? CTRL_NOP : ctrl_i;
      r_rs1_data <= rs1_data_i;
      r_rs2_data <= rs2_data_i;
      r_imm      <= imm_i;
      r_funct    <= funct_i;
      r_rs1_addr <= rs1_addr_i;
      r_rs2_addr <= rs2_addr_i;
      r_rd_addr  <= rd_addr_i;
      r_valid    <= !noop_i;
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_bubble_cnt (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .inc_i   (w_bubble),
    .cnt_o   (bubble_cnt_o)
  );

  assign ctrl_o     = r_ctrl;
  assign rs1_data_o = r_rs1_data;
  assign rs2_data_o = r_rs2_data;
  assign imm_o      = r_imm;
  assign funct_o    = r_funct;
  assign rs1_addr_o = r_rs1_addr;
  assign rs2_addr_o = r_rs2_addr;
  assign rd_addr_o  = r_rd_addr;
  assign valid_o    = r_valid;

endmodule
